multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle sequencer for the ARM-subset datapath. It replaces single-cycle control by stepping one
//  shared ALU/memory port through FETCH/DECODE/EXECUTE/WB states. It issues per-state datapath selects and
//  write strobes, and holds the NZCV flags and the condition-pass bit. It stalls on a memory-ready handshake.
// PARAMETERS
//  FLAG_RST  4'b0000  reset value of NZCV flag register
//  CNT_W     32       width of performance counters (used only with MC_PERF_CNT_EN)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  asynchronous reset, active-low
//  Cond        in   4  instruction [31:28]
//  Op          in   2  instruction [27:26]
//  Funct       in   6  instruction [25:20] (I, cmd[3:0], S/L)
//  Rd          in   4  instruction [15:12]
//  ALUFlags    in   4  NZCV from ALU, current cycle
//  MemReady    in   1  memory completes requested access this cycle
//  MemRead     out  1  memory read request
//  MemWrite    out  1  memory write strobe
//  IRWrite     out  1  load instruction register
//  PCWrite     out  1  load PC
//  RegWrite    out  1  register-file write strobe
//  AdrSrc      out  1  0=PC, 1=ALU result as memory address
//  ALUSrcA     out  1  0=register A, 1=PC
//  ALUSrcB     out  2  0=reg B, 1=extended imm, 2=const 4
//  ResultSrc   out  2  0=ALUOut reg, 1=read data, 2=ALU direct
//  ImmSrc      out  2  0=imm8, 1=imm12, 2=imm24 branch
//  RegSrc      out  2  register-address selects (as decoder)
//  ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
//  State       out  4  current state encoding (debug)
// BEHAVIOUR
//  Reset (rst=0): State=FETCH, flags=FLAG_RST, condex_q=0. All strobes (MemRead/MemWrite/IRWrite/
//   PCWrite/RegWrite) are forced 0 while rst=0, regardless of state. An in-flight access is abandoned
//   with no write. Other outputs follow the FETCH decode.
//  Outputs are Moore-decoded from State. The only Mealy terms are MemReady and condex_q gating, as listed.
//  FETCH: MemRead=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=2.
//   IRWrite=PCWrite=MemReady. Stay in FETCH until MemReady=1, then go to DECODE.
//  DECODE: ALUSrcA=1, ALUSrcB=2, ResultSrc=2. Register condex_q <= CondEx(Cond, flags).
//   Next state: Op=01 -> MEMADR; Op=00,Funct[5]=0 -> EXER; Op=00,Funct[5]=1 -> EXEI;
//   Op=10 -> BRANCH; Op=11 -> FETCH (undefined instruction = NOP).
//  MEMADR: ALUSrcA=0, ALUSrcB=1, ImmSrc=1, ADD. Funct[0]=1 -> MEMRD, else MEMWR.
//  MEMRD: AdrSrc=1, MemRead=condex_q. On MemReady -> MEMWB. If condex_q=0 -> FETCH at once.
//  MEMWB: ResultSrc=1. If Rd=15: PCWrite=condex_q, else RegWrite=condex_q. Then -> FETCH.
//  MEMWR: AdrSrc=1, MemWrite=condex_q. Wait on MemReady -> FETCH. If condex_q=0 -> FETCH at once.
//  EXER/EXEI: ALUSrcA=0, ALUSrcB=0 (EXER) or 1 (EXEI, ImmSrc=0).
//   cmd 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, nowrite). Any other cmd uses ADD
//   with nowrite. If Funct[0] and condex_q: N,Z <= ALUFlags[3:2]; C,V updated only for ADD/SUB/CMP.
//   Next state is ALUWB.
//  ALUWB: ResultSrc=0. Write enabled = condex_q & !nowrite. Rd=15 -> PCWrite, else RegWrite. Then -> FETCH.
//  BRANCH: ALUSrcA=0, ALUSrcB=1, ImmSrc=2, ADD, ResultSrc=2, PCWrite=condex_q. Then -> FETCH.
//   Funct[4] (link) is ignored; BL behaves as B.
//  CondEx uses the stored flags, never same-cycle ALUFlags.
//   Codes 0000-1101 per ARM EQ..LE, 1110 AL=1, 1111 treated as AL.
//  MemReady is ignored when no access is requested. MemReady=1 while already waiting advances exactly once.
// CONFIGURATION
//  MC_PERF_CNT_EN defined: adds outputs CycleCnt[CNT_W-1:0] and InstrRetired[CNT_W-1:0], both reset 0.
//   CycleCnt increments every cycle rst=1. InstrRetired increments on each transition into FETCH from a
//   non-FETCH state. Both wrap modulo 2^CNT_W.
//  Undefined: counters and both ports are absent.
// STRUCTURE
//  cpu_pkg: mc_state_t enum, ALU_ADD/SUB/AND/ORR codes, cmd constants, cond_t codes, ALUSrcB/ResultSrc encodings.
//  Sub-module cond_check: flags register + CondEx evaluation + FlagW split; reused by the single-cycle path.
// TESTING
//  ADD R1,R2,R3 (E0821003), MemReady=1 -> FETCH,DECODE,EXER,ALUWB; RegWrite=1 only in ALUWB.
//  LDR, MemReady held 0 three cycles in MEMRD -> stays MEMRD, MemRead=1; MEMWB follows the ready cycle.
//  SUBS producing Z=1, then BEQ -> BRANCH asserts PCWrite. Same with BNE -> PCWrite=0, next state FETCH.
//  STRNE with Z=1 -> MEMADR then MEMWR; MemWrite never 1; FETCH follows next cycle.
//  rst low mid-MEMWR with MemReady=0 -> State=FETCH immediately, all strobes 0, flags=FLAG_RST.
//  MC_PERF_CNT_EN: 3 instructions from reset -> InstrRetired=3; CycleCnt preset near 2^CNT_W-1 wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the ARM-subset datapath control:
// controller states, ALU/cmd/condition codes, and datapath select encodings.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXER   = 4'd6,
        S_EXEI   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } mc_state_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_RDATA  = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] IMM_8  = 2'd0;
    localparam logic [1:0] IMM_12 = 2'd1;
    localparam logic [1:0] IMM_24 = 2'd2;

    typedef struct packed {
        logic [2:0] alu;
        logic       nowrite;
        logic       cv_upd;
    } dp_dec_t;

    function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
        dp_dec_t d;
        d.alu     = ALU_ADD;
        d.nowrite = 1'b1;
        d.cv_upd  = 1'b0;
        case (cmd)
            CMD_ADD: begin d.alu = ALU_ADD; d.nowrite = 1'b0; d.cv_upd = 1'b1; end
            CMD_SUB: begin d.alu = ALU_SUB; d.nowrite = 1'b0; d.cv_upd = 1'b1; end
            CMD_AND: begin d.alu = ALU_AND; d.nowrite = 1'b0; end
            CMD_ORR: begin d.alu = ALU_ORR; d.nowrite = 1'b0; end
            CMD_CMP: begin d.alu = ALU_SUB; d.cv_upd = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cond_check.sv
// NZCV flag register with split NZ / CV write enables and ARM condition
// evaluation against the stored flags. Shared with the single-cycle path.
module cond_check
    import cpu_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    output logic       cond_ex_o
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    always_comb begin
        flags_d = flags_q;
        if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
        if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= FLAG_RST;
        else        flags_q <= flags_d;
    end

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex_o = 1'b1;
        case (cond_t'(cond_i))
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            default: cond_ex_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle FETCH/DECODE/EXECUTE/WB sequencer with memory-ready stall.
// Optional MC_PERF_CNT_EN adds CycleCnt/InstrRetired performance counters.
module multicycle_controller
    import cpu_pkg::*;
#(
    parameter logic [3:0]  FLAG_RST = 4'b0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstrRetired
`endif
);

    mc_state_t state_q, state_d;
    logic      condex_q, condex_d;
    logic      cond_ex;
    logic      is_exe;
    logic      flag_upd;
    logic [1:0] flag_w;
    dp_dec_t   dp;
    logic      mem_read, mem_write, ir_write, pc_write, reg_write;
    logic      wb_en;
    logic      unused_link;

    // Branch-with-link is executed as a plain branch.
    assign unused_link = Funct[4];

    assign dp       = dp_decode(Funct[4:1]);
    assign is_exe   = (state_q == S_EXER) || (state_q == S_EXEI);
    assign flag_upd = is_exe & Funct[0] & condex_q;
    assign flag_w   = {flag_upd, flag_upd & dp.cv_upd};

    cond_check #(
        .FLAG_RST (FLAG_RST)
    ) u_cond_check (
        .clk         (clk),
        .rst_n       (rst),
        .cond_i      (Cond),
        .alu_flags_i (ALUFlags),
        .flag_w_i    (flag_w),
        .cond_ex_o   (cond_ex)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FETCH;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            condex_q <= condex_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        condex_d   = condex_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        wb_en      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_8;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                ir_write  = MemReady;
                pc_write  = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                condex_d  = cond_ex;
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXEI : S_EXER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_12;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc   = 1'b1;
                mem_read = condex_q;
                if (!condex_q)     state_d = S_FETCH;
                else if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                wb_en     = condex_q;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                mem_write = condex_q;
                if (!condex_q || MemReady) state_d = S_FETCH;
            end
            S_EXER, S_EXEI: begin
                ALUSrcB    = (state_q == S_EXEI) ? SRCB_IMM : SRCB_REG;
                ALUControl = dp.alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                wb_en     = condex_q & ~dp.nowrite;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_24;
                ResultSrc = RES_ALU;
                pc_write  = condex_q;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Writeback to R15 redirects the PC instead of the register file.
        if (wb_en) begin
            if (Rd == 4'd15) pc_write  = 1'b1;
            else             reg_write = 1'b1;
        end
    end

    assign MemRead  = mem_read  & rst;
    assign MemWrite = mem_write & rst;
    assign IRWrite  = ir_write  & rst;
    assign PCWrite  = pc_write  & rst;
    assign RegWrite = reg_write & rst;

    assign RegSrc = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
    assign State  = state_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (state_q != S_FETCH && state_d == S_FETCH)
                ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign CycleCnt     = cyc_q;
    assign InstrRetired = ret_q;
`else
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller; per-cycle vectors of
// instruction fields and expected state/strobes/selects.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       MemRead, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
`ifdef MC_PERF_CNT_EN
    logic [3:0] CycleCnt, InstrRetired;
`endif

    always #5 clk = ~clk;

    multicycle_controller #(
        .FLAG_RST (4'b0000),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .State      (State)
`ifdef MC_PERF_CNT_EN
        ,
        .CycleCnt     (CycleCnt),
        .InstrRetired (InstrRetired)
`endif
    );

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                           MW = 4'd5, XR = 4'd6, XI = 4'd7, AWB = 4'd8, BR = 4'd9;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] fl;
        logic       mr;
        logic [3:0] st;
        logic [4:0] strb;   // {MemRead, MemWrite, IRWrite, PCWrite, RegWrite}
        logic [2:0] m;      // compare mask {ALUControl, ALUSrcB, ResultSrc}
        logic [2:0] alu;
        logic [1:0] srcb;
        logic [1:0] res;
    } vec_t;

    vec_t        tv[$];
    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned vidx   = 0;
    logic [3:0]  cur_c, cur_rd, cur_fl;
    logic [1:0]  cur_op;
    logic [5:0]  cur_f;

`ifdef MC_PERF_CNT_EN
    int unsigned cyc = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end
`endif

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                         input logic [3:0] rd, input logic [3:0] fl);
        cur_c = c; cur_op = op; cur_f = f; cur_rd = rd; cur_fl = fl;
    endtask

    task automatic v(input logic mr, input logic [3:0] st, input logic [4:0] strb,
                     input logic [2:0] m, input logic [2:0] alu, input logic [1:0] srcb,
                     input logic [1:0] res);
        tv.push_back('{cur_c, cur_op, cur_f, cur_rd, cur_fl, mr, st, strb, m, alu, srcb, res});
    endtask

    task automatic apply(input vec_t x);
        Cond = x.cond; Op = x.op; Funct = x.funct; Rd = x.rd; ALUFlags = x.fl; MemReady = x.mr;
        #1;
        chk($sformatf("v%0d.state", vidx), 8'(State), 8'(x.st));
        chk($sformatf("v%0d.strobes", vidx),
            8'({MemRead, MemWrite, IRWrite, PCWrite, RegWrite}), 8'(x.strb));
        if (x.m[2]) chk($sformatf("v%0d.alu", vidx), 8'(ALUControl), 8'(x.alu));
        if (x.m[1]) chk($sformatf("v%0d.srcb", vidx), 8'(ALUSrcB), 8'(x.srcb));
        if (x.m[0]) chk($sformatf("v%0d.res", vidx), 8'(ResultSrc), 8'(x.res));
        vidx++;
        @(negedge clk);
    endtask

    task automatic run_table();
        foreach (tv[i]) apply(tv[i]);
        tv.delete();
    endtask

    initial begin
        rst = 1'b0; Cond = '0; Op = '0; Funct = '0; Rd = '0; ALUFlags = '0; MemReady = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.state", 8'(State), 8'(F));
        chk("reset.strobes", 8'({MemRead, MemWrite, IRWrite, PCWrite, RegWrite}), 8'h00);
        chk("reset.srcb", 8'(ALUSrcB), 8'd2);
        @(negedge clk);
        rst = 1'b1;

        instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000);     // ADD R1,R2,R3
        v(1, F,   5'b10110, 3'b111, 3'b000, 2'd2, 2'd2);
        v(0, D,   5'b00000, 3'b011, 3'b000, 2'd2, 2'd2);
        v(0, XR,  5'b00000, 3'b110, 3'b000, 2'd0, 2'd0);
        v(1, AWB, 5'b00001, 3'b001, 3'b000, 2'd0, 2'd0);
        instr(4'hE, 2'b00, 6'b000101, 4'd4, 4'b0100);     // SUBS -> Z=1
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, XR,  5'b00000, 3'b110, 3'b001, 2'd0, 2'd0);
        v(0, AWB, 5'b00001, 3'b000, 3'b000, 2'd0, 2'd0);
        instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000);     // BEQ taken
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, BR,  5'b00010, 3'b111, 3'b000, 2'd1, 2'd2);
        instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000);     // BNE not taken
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, BR,  5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000);     // LDR with stall
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(1, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(1, MA,  5'b00000, 3'b110, 3'b000, 2'd1, 2'd0);
        v(0, MR,  5'b10000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, MR,  5'b10000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, MR,  5'b10000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(1, MR,  5'b10000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(1, MWB, 5'b00001, 3'b001, 3'b000, 2'd0, 2'd1);
        instr(4'h1, 2'b01, 6'b011000, 4'd3, 4'b0000);     // STRNE with Z=1
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, MA,  5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, MW,  5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b1000);     // CMP -> N=1
        v(0, F,   5'b10000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, XR,  5'b00000, 3'b100, 3'b001, 2'd0, 2'd0);
        v(0, AWB, 5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        instr(4'hB, 2'b00, 6'b111000, 4'd15, 4'b0000);    // ORRLT PC,imm
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, XI,  5'b00000, 3'b110, 3'b011, 2'd1, 2'd0);
        v(0, AWB, 5'b00010, 3'b000, 3'b000, 2'd0, 2'd0);
        instr(4'hA, 2'b00, 6'b001000, 4'd5, 4'b0000);     // ADDGE fails
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, XR,  5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, AWB, 5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);     // undefined -> NOP
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, F,   5'b10000, 3'b000, 3'b000, 2'd0, 2'd0);
        instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);     // STR, memory stalls
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, MA,  5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, MW,  5'b01000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, MW,  5'b01000, 3'b000, 3'b000, 2'd0, 2'd0);
        run_table();

        // Reset asserted mid-MEMWR: abandon the write, back to FETCH at once.
        MemReady = 1'b1;
        rst = 1'b0;
        #1;
        chk("midrst.state", 8'(State), 8'(F));
        chk("midrst.strobes", 8'({MemRead, MemWrite, IRWrite, PCWrite, RegWrite}), 8'h00);
        chk("midrst.srcb", 8'(ALUSrcB), 8'd2);
        @(negedge clk);
        rst = 1'b1;

        // N was set by CMP; after reset flags are 0000 so BMI must not branch.
        instr(4'h4, 2'b10, 6'b100000, 4'd0, 4'b0000);
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, BR,  5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        v(1, F,   5'b10110, 3'b000, 3'b000, 2'd0, 2'd0);
        v(0, D,   5'b00000, 3'b000, 3'b000, 2'd0, 2'd0);
        run_table();

`ifdef MC_PERF_CNT_EN
        #1;
        chk("perf.retired", 8'(InstrRetired), 8'd3);
        chk("perf.cycles", 8'(CycleCnt), 8'(cyc));
        MemReady = 1'b0;
        for (int i = 0; i < 40 && cyc != 16; i++) @(negedge clk);
        #1;
        chk("perf.wait16", 8'(cyc), 8'd16);
        chk("perf.wrap", 8'(CycleCnt), 8'd0);
        chk("perf.retired_idle", 8'(InstrRetired), 8'd3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
